// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and FSM encoding for the instruction-fetch stage
package fetch_stage_pkg;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_1000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
   typedef enum logic [1:0] {FS_REQ, FS_KILL, FS_HOLD} fs_state_t;
endpackage

// File: rtl/fetch_stage_if_skid_buf.sv
// if_skid_buf: one-entry {addr,instr} buffer catching a fetch response while the decoder stalls
module if_skid_buf (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        load,
   input  logic        drain,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_instr,
   output logic [31:0] addr,
   output logic [31:0] instr,
   output logic        full
);
   // clear wins over load so a redirect never leaves a stale entry behind
   always_ff @(posedge clk) begin
      if (reset || clear) full <= 1'b0;
      else if (load) begin
         full  <= 1'b1;
         addr  <= load_addr;
         instr <= load_instr;
      end else if (drain) full <= 1'b0;
   end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory request handshake and IF/ID register with stall/redirect
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   output logic [31:0] pc_out,
   output logic        ir_valid
);
   fs_state_t   state, state_next;
   logic [31:0] pc, pc_next, addr_next, skid_addr, skid_instr;
   logic        req_next, skid_full, fire, accept;
   assign fire   = imem_req & imem_ready;
   assign accept = fire & (state == FS_REQ) & ~redirect;
   if_skid_buf skid (
      .clk        (clk),
      .reset      (reset),
      .clear      (redirect),
      .load       (accept & stall),
      .drain      (~stall & skid_full),
      .load_addr  (imem_addr),
      .load_instr (imem_rdata),
      .addr       (skid_addr),
      .instr      (skid_instr),
      .full       (skid_full)
   );
   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= FS_REQ;
      else state <= state_next;
   end
   // next state: redirect with a request still open must swallow its late response
   always_comb begin
      state_next = state;
      if (redirect) state_next = (imem_req & ~imem_ready) ? FS_KILL : FS_REQ;
      else if (state == FS_KILL) state_next = fire ? FS_REQ : FS_KILL;
      else if (state == FS_HOLD) state_next = stall ? FS_HOLD : FS_REQ;
      else state_next = (accept & stall) ? FS_HOLD : FS_REQ;
   end
   // outputs: next PC, request enable, and fetch address (frozen on the stale address while killing)
   always_comb begin
      pc_next   = redirect ? {redirect_pc[31:2], 2'b00} : accept ? pc + 32'd4 : pc;
      req_next  = state_next != FS_HOLD;
      addr_next = (state_next == FS_KILL) ? imem_addr : pc_next;
   end
   // PC and memory-port registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc        <= RESET_PC;
         imem_addr <= RESET_PC;
         imem_req  <= 1'b0;
      end else begin
         pc        <= pc_next;
         imem_addr <= addr_next;
         imem_req  <= req_next;
      end
   end
   // IF/ID register: redirect bubbles, skid drains before fresh data, stall holds
   always_ff @(posedge clk) begin
      if (reset) begin
         ir       <= NOP_INSTR;
         pc_out   <= '0;
         ir_valid <= 1'b0;
      end else if (redirect) begin
         ir       <= NOP_INSTR;
         ir_valid <= 1'b0;
      end else if (!stall && skid_full) begin
         ir       <= skid_instr;
         pc_out   <= skid_addr;
         ir_valid <= 1'b1;
      end else if (!stall && accept) begin
         ir       <= imem_rdata;
         pc_out   <= imem_addr;
         ir_valid <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench with a latency-configurable instruction memory model
module tb_fetch_stage;
   logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, redirect = 1'b0, imem_ready = 1'b0;
   logic [31:0] redirect_pc = '0, imem_rdata = '0;
   logic        imem_req, ir_valid;
   logic [31:0] imem_addr, ir, pc_out;
   int          errors = 0, checks = 0, lat = 1, cnt = 0;
   bit          busy = 0, kill = 0, pv = 0;
   logic [31:0] ppc = '0, cur_addr = '0, resp_addr = '0, last_pc = '0, held, nxt, stale;
   logic [31:0] q[$];
   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .ir          (ir),
      .pc_out      (pc_out),
      .ir_valid    (ir_valid)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h00A0_0093;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      logic [31:0] e;
      if (imem_ready && !reset) begin
         if (kill) kill = 0;
         else q.push_back(resp_addr);
      end
      @(posedge clk);
      #1;
      if (ir_valid && (!pv || pc_out != ppc)) begin
         e = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
         check("pc_out", pc_out, e);
         check("ir", ir, instr_of(e));
         last_pc = pc_out;
      end
      pv = ir_valid;
      ppc = pc_out;
      imem_ready = 1'b0;
      if (imem_req) begin
         if (busy) check("addr_stable", imem_addr, cur_addr);
         else begin
            busy = 1;
            cur_addr = imem_addr;
            cnt = 0;
         end
         cnt++;
         if (cnt >= lat) begin
            imem_ready = 1'b1;
            imem_rdata = instr_of(cur_addr);
            resp_addr = cur_addr;
            busy = 0;
         end
      end else busy = 0;
   endtask
   task automatic wait_outstanding();
      for (int i = 0; i < 50; i++) begin
         if (imem_req && busy && !imem_ready) break;
         tick();
      end
      check("outstanding", 32'(imem_req && busy && !imem_ready), 32'd1);
   endtask
   task automatic wait_ready();
      for (int i = 0; i < 50; i++) begin
         if (imem_ready) break;
         tick();
      end
      check("ready_seen", 32'(imem_ready), 32'd1);
   endtask
   initial begin
      repeat (3) tick();
      check("rst_ir", ir, 32'h0000_0013);
      check("rst_valid", 32'(ir_valid), 32'd0);
      check("rst_pc_out", pc_out, 32'd0);
      check("rst_req", 32'(imem_req), 32'd0);
      reset = 1'b0;
      tick();
      check("first_req", 32'(imem_req), 32'd1);
      check("first_addr", imem_addr, 32'h0000_1000);
      tick();
      check("first_valid", 32'(ir_valid), 32'd1);
      check("first_ir", ir, 32'h00A0_1093);
      check("first_pc_out", pc_out, 32'h0000_1000);
      repeat (5) tick();
      lat = 3;
      repeat (12) tick();
      stall = 1'b1;
      held = pc_out;
      repeat (8) tick();
      check("hold_req", 32'(imem_req), 32'd0);
      check("skid_entry", 32'(q.size()), 32'd1);
      check("stall_hold_pc", pc_out, held);
      nxt = q[0] + 32'd4;
      stall = 1'b0;
      tick();
      check("skid_drain", pc_out, nxt - 32'd4);
      check("resume_req", 32'(imem_req), 32'd1);
      check("resume_addr", imem_addr, nxt);
      repeat (4) tick();
      wait_outstanding();
      stale = cur_addr;
      redirect = 1'b1;
      redirect_pc = 32'h0000_2002;
      kill = 1;
      q.delete();
      tick();
      redirect = 1'b0;
      check("kill_ir", ir, 32'h0000_0013);
      check("kill_valid", 32'(ir_valid), 32'd0);
      check("kill_req", 32'(imem_req), 32'd1);
      check("kill_addr", imem_addr, stale);
      repeat (12) tick();
      check("post_kill_page", {12'b0, last_pc[31:12]}, 32'h2);
      wait_ready();
      stall = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h0000_3000;
      kill = imem_req;
      q.delete();
      tick();
      redirect = 1'b0;
      check("same_valid", 32'(ir_valid), 32'd0);
      check("same_ir", ir, 32'h0000_0013);
      check("same_req", 32'(imem_req), 32'd1);
      check("same_addr", imem_addr, 32'h0000_3000);
      repeat (6) tick();
      stall = 1'b0;
      repeat (10) tick();
      check("post_same_page", {12'b0, last_pc[31:12]}, 32'h3);
      lat = 1;
      tick();
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      kill = imem_req;
      q.delete();
      tick();
      redirect = 1'b0;
      repeat (6) tick();
      check("wrap_low", {8'b0, last_pc[31:8]}, 32'd0);
      lat = 3;
      wait_outstanding();
      reset = 1'b1;
      kill = 0;
      q.delete();
      tick();
      check("mid_rst_req", 32'(imem_req), 32'd0);
      check("mid_rst_ir", ir, 32'h0000_0013);
      check("mid_rst_valid", 32'(ir_valid), 32'd0);
      reset = 1'b0;
      tick();
      check("restart_req", 32'(imem_req), 32'd1);
      check("restart_addr", imem_addr, 32'h0000_1000);
      repeat (10) tick();
      check("restart_page", {12'b0, last_pc[31:12]}, 32'h1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
